// File: rtl/otter_lsu_if.sv
// otter_lsu_if: bundle of the LSU's pipeline-side and memory-side signals.
//   REQ_*     : request from the execute/memory stage (valid/ready handshake)
//   RSP_*     : tagged response back to the pipeline
//   MEM_*     : OTTER data-memory port 2 (initiator side is the LSU)
// Modports:
//   master : the LSU itself (drives REQ_READY, RSP_*, MEM_* controls)
//   slave  : the surrounding pipeline and memory
interface otter_lsu_if;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic [1:0]  REQ_SIZE;
    logic        REQ_SIGN;
    logic [4:0]  REQ_RD;

    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic [4:0]  RSP_RD;
    logic        RSP_ERR;
    logic        RSP_IO;

    logic        MEM_RDEN2;
    logic        MEM_WE2;
    logic [31:0] MEM_ADDR2;
    logic [31:0] MEM_DIN2;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_DOUT2;

    modport master (
        input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_SIZE, REQ_SIGN, REQ_RD,
        output REQ_READY,
        output RSP_VALID, RSP_RDATA, RSP_RD, RSP_ERR, RSP_IO,
        output MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN,
        input  MEM_DOUT2
    );

    modport slave (
        output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_SIZE, REQ_SIGN, REQ_RD,
        input  REQ_READY,
        input  RSP_VALID, RSP_RDATA, RSP_RD, RSP_ERR, RSP_IO,
        input  MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN,
        output MEM_DOUT2
    );
endinterface

// File: rtl/otter_lsu.sv
// otter_lsu: load/store unit driving OTTER data-memory port 2.
// Accepts one request at a time, sequences the memory's one-cycle synchronous
// read, and returns a tagged response pulse.
// Ports:
//   CLK    : system clock, rising edge
//   RST_N  : asynchronous active-low reset
//   bus    : otter_lsu_if.master (REQ_*, RSP_*, MEM_* signals)
// Parameters:
//   IO_BASE       : first memory-mapped IO address (sets RSP_IO)
//   MISALIGN_TRAP : 1 = illegal size/offset combinations answer with RSP_ERR
module otter_lsu #(
    parameter logic [31:0] IO_BASE       = 32'h0001_0000,
    parameter bit          MISALIGN_TRAP = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    otter_lsu_if.master bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_d;
    logic        we_q;
    logic [4:0]  rd_q;

    logic        accept;
    logic        we_n;
    logic [4:0]  rd_n;
    logic [31:0] addr_n;

    logic        rden_d;
    logic        wen_d;
    logic        rsp_vld_d;
    logic        rsp_err_d;
    logic        rsp_io_d;
    logic [31:0] rsp_rdata_d;

    // Half-words may straddle bytes 1..2 of a word but not cross into the next word.
    function automatic logic access_legal(input logic [1:0] size, input logic [1:0] offset);
        logic ok;
        case (size)
            2'd0:    ok = 1'b1;
            2'd1:    ok = (offset != 2'd3);
            2'd2:    ok = (offset == 2'd0);
            default: ok = 1'b0;
        endcase
        access_legal = ok;
    endfunction

    assign accept        = (state == IDLE) && bus.REQ_VALID;
    assign bus.REQ_READY = (state == IDLE);

    // Values that will be "current" after this edge: the request on an accept,
    // otherwise what was latched earlier. Lets errors respond one cycle after accept.
    assign we_n   = accept ? bus.REQ_WE   : we_q;
    assign rd_n   = accept ? bus.REQ_RD   : rd_q;
    assign addr_n = accept ? bus.REQ_ADDR : bus.MEM_ADDR2;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (bus.REQ_VALID) begin
                    if (MISALIGN_TRAP && !access_legal(bus.REQ_SIZE, bus.REQ_ADDR[1:0])) begin
                        state_d = ERR;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE:   state_d = we_q ? RESP : WAIT;
            WAIT:    state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so their D inputs are decoded from the next state.
    always_comb begin
        rden_d      = (state_d == ISSUE) && !we_n;
        wen_d       = (state_d == ISSUE) && we_n;
        rsp_vld_d   = (state_d == RESP) || (state_d == ERR);
        rsp_err_d   = (state_d == ERR);
        rsp_io_d    = (addr_n >= IO_BASE);
        // Only a load leaving WAIT carries data; stores and errors report zero.
        rsp_rdata_d = (state == WAIT) ? bus.MEM_DOUT2 : 32'd0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            we_q          <= 1'b0;
            rd_q          <= 5'd0;
            bus.MEM_ADDR2 <= 32'd0;
            bus.MEM_DIN2  <= 32'd0;
            bus.MEM_SIZE  <= 2'd0;
            bus.MEM_SIGN  <= 1'b0;
            bus.MEM_RDEN2 <= 1'b0;
            bus.MEM_WE2   <= 1'b0;
            bus.RSP_VALID <= 1'b0;
            bus.RSP_RDATA <= 32'd0;
            bus.RSP_RD    <= 5'd0;
            bus.RSP_ERR   <= 1'b0;
            bus.RSP_IO    <= 1'b0;
        end else begin
            // Address/size/sign stay held through WAIT: the memory sizes its
            // registered read word using the current address and size.
            if (accept) begin
                we_q          <= bus.REQ_WE;
                rd_q          <= bus.REQ_RD;
                bus.MEM_ADDR2 <= bus.REQ_ADDR;
                bus.MEM_DIN2  <= bus.REQ_WDATA;
                bus.MEM_SIZE  <= bus.REQ_SIZE;
                bus.MEM_SIGN  <= bus.REQ_SIGN;
            end
            bus.MEM_RDEN2 <= rden_d;
            bus.MEM_WE2   <= wen_d;
            bus.RSP_VALID <= rsp_vld_d;
            if (rsp_vld_d) begin
                bus.RSP_RDATA <= rsp_rdata_d;
                bus.RSP_RD    <= rd_n;
                bus.RSP_ERR   <= rsp_err_d;
                bus.RSP_IO    <= rsp_io_d;
            end
        end
    end
endmodule
